// File: rtl/mxv_result_tx_pkg.sv
// Shared definitions for the MxV result transmitter: byte type, frame
// delimiters and the transmit FSM state encoding.
// No logic, no latency, no flow control.
package mxv_result_tx_pkg;

   typedef logic [7:0] word_lenght_t;

   localparam word_lenght_t FRAME_HEADER = 8'hFE;
   localparam word_lenght_t FRAME_FOOTER = 8'hEF;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LEN,
      RD_WAIT,
      RD_LATCH,
      SEND_BYTE,
      FTR,
      DONE
   } tx_state_t;

endpackage

// File: rtl/mxv_tx_word_reg.sv
// Result word holding register with MSB-first byte selection.
// Latency: word visible on byte_out the cycle after load; byte_sel is combinational.
// Backpressure: none; load is honoured whenever asserted.
// Ports: clk/rst (sync, active-high), load + din capture a word,
//        byte_sel picks byte 0 = most significant, byte_out is that byte.
module mxv_tx_word_reg
   import mxv_result_tx_pkg::*;
#(
   parameter  int RESULT_W = 16,
   localparam int BYTES    = RESULT_W / 8,
   localparam int BSEL_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [RESULT_W-1:0] din,
   input  logic [BSEL_W-1:0]   byte_sel,
   output logic [7:0]          byte_out
);

   logic [RESULT_W-1:0] word_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
      end else if (load) begin
         word_q <= din;
      end
   end

   // Byte 0 is the top slice so the counter can simply count upward.
   always_comb begin
      byte_out = word_q[8*(BYTES-1-int'(byte_sel)) +: 8];
   end

endmodule

// File: rtl/mxv_result_tx.sv
// Reads N result words from the result RAM and sends them framed
// (FE, length, word bytes MSB first, EF) through the UART transmitter.
// Latency: first TX_START one cycle after START; 3 cycles from a word's first
// TX_DONE boundary to its MSB TX_START (RAM read + latch).
// Backpressure: each byte is held on TX_DATA until the UART returns TX_DONE.
// Ports: START/VEC_N request a frame, RES_ADDR/RES_DATA read the sync RAM,
//        TX_DATA/TX_START/TX_DONE talk to the UART, BUSY/DONE_TRANSMITION report status.
module mxv_result_tx
   import mxv_result_tx_pkg::*;
#(
   parameter  int RESULT_W = 16,
   parameter  int MAX_N    = 8,
   localparam int ADDR_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                START,
   input  logic [3:0]          VEC_N,
   output logic [ADDR_W-1:0]   RES_ADDR,
   input  logic [RESULT_W-1:0] RES_DATA,
   output logic [7:0]          TX_DATA,
   output logic                TX_START,
   input  logic                TX_DONE,
   output logic                BUSY,
   output logic                DONE_TRANSMITION
);

   localparam int BYTES  = RESULT_W / 8;
   localparam int BSEL_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   // One extra bit so N = MAX_N and the post-last-word index both fit.
   localparam int CNT_W  = ADDR_W + 1;

   tx_state_t        state_q, state_d;
   logic             first_q, first_d;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W-1:0] idx_q;
   logic [BSEL_W-1:0] byte_q;
   logic [CNT_W-1:0] vec_clamped;
   logic             word_load;
   word_lenght_t     word_byte;
   logic             send_st;
   logic             done_acc;
   logic             last_byte;
   logic             last_word;

   mxv_tx_word_reg #(
      .RESULT_W (RESULT_W)
   ) u_word_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (word_load),
      .din      (RES_DATA),
      .byte_sel (byte_q),
      .byte_out (word_byte)
   );

   assign vec_clamped = (int'(VEC_N) > MAX_N) ? CNT_W'(MAX_N) : CNT_W'(VEC_N);

   assign send_st   = (state_q == HDR) || (state_q == LEN) ||
                      (state_q == SEND_BYTE) || (state_q == FTR);
   // A TX_DONE coinciding with our own TX_START belongs to an earlier byte.
   assign done_acc  = TX_DONE && send_st && !first_q;
   assign last_byte = (byte_q == BSEL_W'(BYTES - 1));
   assign last_word = ((idx_q + 1'b1) == n_q);

   assign TX_START         = send_st && first_q;
   assign BUSY             = (state_q != IDLE);
   assign DONE_TRANSMITION = (state_q == DONE);
   assign RES_ADDR         = idx_q[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      word_load = 1'b0;
      TX_DATA   = 8'h00;
      case (state_q)
         IDLE: begin
            if (START) state_d = HDR;
         end
         HDR: begin
            TX_DATA = FRAME_HEADER;
            if (done_acc) state_d = LEN;
         end
         LEN: begin
            TX_DATA = 8'(int'(n_q) * BYTES);
            if (done_acc) state_d = (n_q != '0) ? RD_WAIT : FTR;
         end
         RD_WAIT: begin
            state_d = RD_LATCH;
         end
         RD_LATCH: begin
            word_load = 1'b1;
            state_d   = SEND_BYTE;
         end
         SEND_BYTE: begin
            TX_DATA = word_byte;
            if (done_acc && last_byte) state_d = last_word ? FTR : RD_WAIT;
         end
         FTR: begin
            TX_DATA = FRAME_FOOTER;
            if (done_acc) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A fresh byte starts on every state change and on each inner byte of a word.
      first_d = (state_d != state_q) ||
                ((state_q == SEND_BYTE) && done_acc && !last_byte);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q    <= '0;
         idx_q  <= '0;
         byte_q <= '0;
      end else begin
         if ((state_q == IDLE) && START) n_q <= vec_clamped;
         if (state_q == DONE) begin
            idx_q  <= '0;
            byte_q <= '0;
         end else if ((state_q == SEND_BYTE) && done_acc) begin
            if (last_byte) begin
               byte_q <= '0;
               idx_q  <= idx_q + 1'b1;
            end else begin
               byte_q <= byte_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mxv_result_tx.sv
// Randomized bench for mxv_result_tx: a UART responder with configurable
// TX_DONE delay, a synchronous result RAM and a frame-level reference model.
// Ports of the DUT are all driven/observed here.
module tb_mxv_result_tx;

   localparam int RESULT_W = 16;
   localparam int MAX_N    = 8;
   localparam int ADDR_W   = 3;
   localparam int BYTES    = RESULT_W / 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                START;
   logic [3:0]          VEC_N;
   logic [ADDR_W-1:0]   RES_ADDR;
   logic [RESULT_W-1:0] RES_DATA;
   logic [7:0]          TX_DATA;
   logic                TX_START;
   logic                TX_DONE;
   logic                BUSY;
   logic                DONE_TRANSMITION;

   mxv_result_tx #(
      .RESULT_W (RESULT_W),
      .MAX_N    (MAX_N)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .START            (START),
      .VEC_N            (VEC_N),
      .RES_ADDR         (RES_ADDR),
      .RES_DATA         (RES_DATA),
      .TX_DATA          (TX_DATA),
      .TX_START         (TX_START),
      .TX_DONE          (TX_DONE),
      .BUSY             (BUSY),
      .DONE_TRANSMITION (DONE_TRANSMITION)
   );

   always #5 clk = ~clk;

   logic [RESULT_W-1:0] ram [MAX_N];
   always @(posedge clk) RES_DATA <= ram[RES_ADDR];

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         st_q[$];
   int         done_cnt;
   int         done_cyc;
   int         busy_low;
   int         max_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_start"}, TX_START, 0);
      check({tag, "_tx_data"}, TX_DATA, 8'h00);
      check({tag, "_busy"}, BUSY, 0);
      check({tag, "_res_addr"}, RES_ADDR, 0);
      check({tag, "_done"}, DONE_TRANSMITION, 0);
   endtask

   // Frame content straight from the framing rules.
   task automatic model_frame(input int vec_n);
      int n;
      n = (vec_n > MAX_N) ? MAX_N : vec_n;
      exp_q.delete();
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'(n * BYTES));
      for (int i = 0; i < n; i++)
         for (int b = BYTES - 1; b >= 0; b--)
            exp_q.push_back(ram[i][8*b +: 8]);
      exp_q.push_back(8'hEF);
   endtask

   // Runs one frame. noise: TX_DONE in IDLE, START mid-frame and in DONE.
   // abort_after > 0: pulse rst right after that many TX_STARTs.
   task automatic run_frame(input int vec_n, input int dly, input bit noise, input int abort_after);
      int cnt = 0;
      int c;
      got_q.delete(); st_q.delete();
      done_cnt = 0; done_cyc = -1; busy_low = -1; max_addr = 0;
      TX_DONE = 1'b0;
      if (noise) begin
         TX_DONE = 1'b1;
         tick();
         TX_DONE = 1'b0;
      end
      VEC_N = 4'(vec_n);
      START = 1'b1;
      tick();
      START = 1'b0;
      c = 1;
      check("busy_after_start", BUSY, 1);
      while (c < 3000) begin
         if (int'(RES_ADDR) > max_addr) max_addr = int'(RES_ADDR);
         if (DONE_TRANSMITION) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && !BUSY && busy_low < 0) busy_low = c;
         TX_DONE = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               TX_DONE = 1'b1;
               check("tx_data_stable", TX_DATA, got_q[$]);
            end
         end
         if (TX_START) begin
            got_q.push_back(TX_DATA);
            st_q.push_back(c);
            cnt = dly;
            if (abort_after > 0 && got_q.size() == abort_after) begin
               TX_DONE = 1'b0;
               START   = 1'b0;
               rst     = 1'b1;
               tick();
               rst = 1'b0;
               check_reset_outputs("after_rst");
               return;
            end
         end
         START = noise && ((TX_START && got_q.size() == 3) || DONE_TRANSMITION);
         if (busy_low >= 0 && c >= busy_low + 6) break;
         tick();
         c++;
      end
      START = 1'b0;
      TX_DONE = 1'b0;
      check("frame_completed", busy_low >= 0, 1);
   endtask

   task automatic verify_frame(input int vec_n, input int dly);
      int t;
      int gap;
      int m;
      model_frame(vec_n);
      check("byte_count", got_q.size(), exp_q.size());
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
      check("done_pulses", done_cnt, 1);
      check("busy_low_after_done", busy_low, done_cyc + 1);
      check("res_addr_idle", RES_ADDR, 0);
      if (st_q.size() > 0) begin
         check("first_tx_start_cycle", st_q[0], 1);
         check("done_after_footer", done_cyc, st_q[st_q.size()-1] + dly + 1);
      end
      t = 1;
      for (int i = 1; i < m; i++) begin
         // The first byte of each word needs a RAM read and a latch first.
         gap = dly + ((i >= 2 && i <= exp_q.size() - 2 && (i - 2) % BYTES == 0) ? 3 : 1);
         t += gap;
         check($sformatf("tx_start_cycle%0d", i), st_q[i], t);
      end
   endtask

   initial begin
      int v;
      int d;
      rst = 1'b1; START = 1'b0; VEC_N = '0; TX_DONE = 1'b0;
      for (int i = 0; i < MAX_N; i++) ram[i] = RESULT_W'($urandom);
      tick(); tick();
      rst = 1'b0;
      check_reset_outputs("reset");
      tick();

      ram[0] = 16'h1234; ram[1] = 16'hABCD;
      run_frame(2, 3, 1'b0, 0);
      verify_frame(2, 3);
      check("res_addr_max_n2", max_addr, 2);

      d = $urandom_range(1, 4);
      run_frame(0, d, 1'b0, 0);
      verify_frame(0, d);
      check("res_addr_n0", max_addr, 0);

      for (int i = 0; i < MAX_N; i++) ram[i] = RESULT_W'(16'h0101 * i);
      run_frame(12, 2, 1'b0, 0);
      verify_frame(12, 2);

      for (int i = 0; i < MAX_N; i++) ram[i] = RESULT_W'($urandom);
      run_frame(3, 2, 1'b1, 0);
      verify_frame(3, 2);

      run_frame(2, 2, 1'b0, 3);
      tick();
      ram[0] = 16'h00FF;
      run_frame(1, 2, 1'b0, 0);
      verify_frame(1, 2);

      run_frame(1, 1, 1'b0, 0);
      verify_frame(1, 1);

      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < MAX_N; i++) ram[i] = RESULT_W'($urandom);
         v = $urandom_range(0, 15);
         d = $urandom_range(1, 4);
         run_frame(v, d, 1'($urandom_range(0, 1)), 0);
         verify_frame(v, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mxv_result_tx.md
# mxv_result_tx

Result transmitter for the matrix-vector multiplier: the outbound counterpart of the byte receive path. When the operation stage finishes, it reads the N result words from the result RAM and sends them as a framed byte stream through the UART transmitter. It sits between the result RAM and the UART TX, is started by the MxV state machine, and reports completion back to it.

## Interface
Parameters:
- RESULT_W, 16: width of one result word; must be a multiple of 8 (bytes sent MSB first).
- MAX_N, 8: maximum vector length; ADDR_W = $clog2(MAX_N).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- START  in  1  one-cycle request to send a frame; accepted only in IDLE.
- VEC_N  in  4  number of result words; latched on accepted START.
- RES_ADDR  out  ADDR_W  result RAM read address.
- RES_DATA  in  RESULT_W  result RAM read data, valid one cycle after RES_ADDR changes (synchronous RAM).
- TX_DATA  out  8 (word_lenght_t)  byte to the UART TX; stable from TX_START until the matching TX_DONE.
- TX_START  out  1  one-cycle pulse: UART TX may load TX_DATA.
- TX_DONE  in  1  one-cycle pulse from the UART TX: byte finished.
- BUSY  out  1  high from the cycle after an accepted START through the DONE_TRANSMITION cycle.
- DONE_TRANSMITION  out  1  one-cycle pulse after the footer byte completes.

## Operation
- Frame: header 0xFE, length byte = 2·N (for RESULT_W=16), then for i = 0..N-1 the bytes of word i, MSB first, then footer 0xEF.
- N = VEC_N clamped to MAX_N. N = 0 sends FE, 00, EF and performs no RAM reads.
- FSM states: IDLE, HDR, LEN, RD_WAIT, RD_LATCH, SEND_BYTE, FTR, DONE.
- Each send state drives TX_DATA, pulses TX_START on its first cycle, then waits for TX_DONE.
- Transitions:
  - IDLE→HDR on START.
  - HDR→LEN on TX_DONE.
  - LEN→RD_WAIT on TX_DONE if N>0, else LEN→FTR.
  - RD_WAIT→RD_LATCH after 1 cycle. RD_LATCH captures RES_DATA into the word register, then →SEND_BYTE.
  - In SEND_BYTE, each TX_DONE advances the byte counter. After the last byte of a word, the index increments: →RD_WAIT if index<N, else →FTR.
  - FTR→DONE on TX_DONE. DONE→IDLE after 1 cycle.
- RES_ADDR = index register. It is 0 in IDLE and updates on the same edge that samples the last byte's TX_DONE.
- TX_DONE is ignored in IDLE, RD_WAIT, RD_LATCH and DONE, and on the TX_START cycle itself.
- START is ignored while not in IDLE, including during the DONE cycle.
- rst mid-frame: the next cycle is IDLE with reset outputs. No footer is sent and no DONE_TRANSMITION is pulsed. The UART TX shares rst.
- Reset values: TX_DATA 0x00, TX_START 0, RES_ADDR 0, BUSY 0, DONE_TRANSMITION 0.

## Timing
- START sampled at cycle 0 → BUSY=1 and TX_START with TX_DATA=0xFE at cycle 1.
- TX_DONE sampled at cycle k in HDR, FTR, or a non-final SEND_BYTE byte → next TX_START at k+1.
- Word boundary or LEN→first word: TX_DONE at k → RES_ADDR new at k+1, word latched at k+2, TX_START of the MSB at k+3.
- Footer TX_DONE at k → DONE_TRANSMITION=1 at k+1, BUSY=0 at k+2. The earliest accepted START is at k+2.
- Minimum per byte: 2 cycles (TX_DONE the cycle after TX_START).

## Structure
- Definitions_Package: word_lenght_t (8-bit), FRAME_HEADER=8'hFE, FRAME_FOOTER=8'hEF, and the tx_state_t enum.
- One sub-module is natural: mxv_tx_word_reg, a load-enabled RESULT_W register with a byte-select output (byte index → 8-bit slice, MSB first).
- FSM, index counter, byte counter and N latch live in mxv_result_tx.

## Test plan
- MAX_N=8, VEC_N=2, RAM[0]=0x1234, RAM[1]=0xABCD, TX_DONE 3 cycles after each TX_START → bytes FE,04,12,34,AB,CD,EF; RES_ADDR 0 then 1; exactly one DONE_TRANSMITION pulse, then BUSY=0.
- VEC_N=0 → bytes FE,00,EF; RES_ADDR stays 0; DONE_TRANSMITION pulses once.
- VEC_N=12 (> MAX_N=8), RAM[i]=0x0101·i → length 0x10; 8 words from addresses 0..7; footer EF.
- START re-pulsed mid-frame, TX_DONE pulsed in IDLE, and START during the DONE cycle → byte stream unchanged; no extra frame.
- rst for 1 cycle after the 3rd TX_START, then START with VEC_N=1, RAM[0]=0x00FF → reset values on the cycle after rst; full new frame FE,02,00,FF,EF.
- TX_DONE always one cycle after TX_START, VEC_N=1 → TX_START spacing is 2 cycles, except the 3-cycle gap before the word MSB.
